// File: rtl/rtc_seq_pkg.sv
// Shared types for the RTC multiplexed-AD bus sequencer: state encoding,
// the strobe bundle driven onto the pads, and the strobe pattern per phase.
package rtc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP1,
    ST_DATA,
    ST_GAP2,
    ST_FIN
  } state_t;

  // Strobes are active-low; ad_oe is active-high (1 = master drives AD).
  typedef struct packed {
    logic ad_n;
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic ad_oe;
  } strobe_t;

  localparam strobe_t STB_IDLE    = '{ad_n: 1'b1, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad_oe: 1'b0};
  localparam strobe_t STB_ADDR    = '{ad_n: 1'b0, cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, ad_oe: 1'b1};
  localparam strobe_t STB_DATA_WR = '{ad_n: 1'b1, cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, ad_oe: 1'b1};
  localparam strobe_t STB_DATA_RD = '{ad_n: 1'b1, cs_n: 1'b0, rd_n: 1'b0, wr_n: 1'b1, ad_oe: 1'b0};

  // Strobe pattern for a state; read DATA never drives AD, so rd_n low
  // and ad_oe high can never coexist.
  function automatic strobe_t phase_strobes(input state_t st, input logic is_write);
    strobe_t s;
    case (st)
      ST_ADDR: s = STB_ADDR;
      ST_DATA: s = is_write ? STB_DATA_WR : STB_DATA_RD;
      default: s = STB_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus-phase timer: counts T_PHASE-1 down to 0 and flags the last cycle of
// every phase with tc. Reloads on tc or when restart is held.
module rtc_phase_timer #(
  parameter int T_PHASE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tc
);

  localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [CW-1:0] LOAD = CW'(T_PHASE - 1);

  logic [CW-1:0] r_cnt;

  // Down-counter reloading at the end of each phase or while parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= LOAD;
    else if (i_restart || (r_cnt == '0))
      r_cnt <= LOAD;
    else
      r_cnt <= r_cnt - CW'(1);
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Burst bus master for the multiplexed-AD RTC interface. Runs up to DEPTH
// consecutive-address reads or writes, each as ADDR/GAP1/DATA/GAP2 phases of
// T_PHASE cycles. Optional write read-back verify: define RTC_SEQ_VERIFY_EN.
module rtc_bus_sequencer
  import rtc_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 8,
  parameter int T_PHASE = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic                       i_wr_op,
  input  logic [ADDR_W-1:0]          i_base_addr,
  input  logic [$clog2(DEPTH+1)-1:0] i_count,
  input  logic [DEPTH*DATA_W-1:0]    i_wdata,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_aborted,
  output logic [DEPTH*DATA_W-1:0]    o_rdata,
  output logic                       o_err,
  output logic                       o_ad_n,
  output logic                       o_cs_n,
  output logic                       o_rd_n,
  output logic                       o_wr_n,
  output logic [DATA_W-1:0]          o_ad_out,
  output logic                       o_ad_oe,
  input  logic [DATA_W-1:0]          i_ad_in
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic               r_vfy, w_vfy_next;     // 1 = read-back pass of a write
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wr;
  logic [ADDR_W-1:0]  r_base;
  logic [DATA_W-1:0]  r_wdata [DEPTH];
  strobe_t            r_stb, w_stb_next;
  logic [DATA_W-1:0]  r_ad_out, w_ad_out_next;
  logic               r_busy, r_done, r_aborted;

  logic               w_tc, w_restart, w_accept, w_in_phase, w_last, w_abort_hit;
  logic               w_wr_next, w_is_write_next, w_capture;
  logic [CNT_W-1:0]   w_cnt_sat;
  logic [ADDR_W-1:0]  w_base_next, w_addr_next;

  rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .o_tc      (w_tc)
  );

  assign w_in_phase  = (r_state == ST_ADDR) || (r_state == ST_GAP1) ||
                       (r_state == ST_DATA) || (r_state == ST_GAP2);
  assign w_restart   = !w_in_phase;
  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_cnt_sat   = (i_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_count;
  assign w_last      = (CNT_W'(r_idx) + CNT_W'(1)) == r_cnt;
  assign w_wr_next   = w_accept ? i_wr_op : r_wr;
  assign w_base_next = w_accept ? i_base_addr : r_base;
  // Capture on the last DATA cycle of a real read; an abort in that cycle wins.
  assign w_capture   = (r_state == ST_DATA) && w_tc && !i_abort && !r_wr;

  // Next-state logic plus the decoded pad values for the next cycle.
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_vfy_next    = r_vfy;
    w_abort_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = (w_cnt_sat == '0) ? ST_FIN : ST_ADDR;
          w_idx_next   = '0;
          w_vfy_next   = 1'b0;
        end
      end
      ST_ADDR: if (w_tc) w_state_next = ST_GAP1;
      ST_GAP1: if (w_tc) w_state_next = ST_DATA;
      ST_DATA: if (w_tc) w_state_next = ST_GAP2;
      ST_GAP2: begin
        if (w_tc) begin
`ifdef RTC_SEQ_VERIFY_EN
          if (r_wr && !r_vfy) begin
            w_vfy_next   = 1'b1;
            w_state_next = ST_ADDR;
          end else
`endif
          begin
            w_vfy_next = 1'b0;
            if (w_last) begin
              w_state_next = ST_FIN;
            end else begin
              w_idx_next   = r_idx + IDX_W'(1);
              w_state_next = ST_ADDR;
            end
          end
        end
      end
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (i_abort && w_in_phase) begin
      w_state_next = ST_FIN;
      w_abort_hit  = 1'b1;
    end

    w_is_write_next = w_wr_next && !w_vfy_next;
    w_stb_next      = phase_strobes(w_state_next, w_is_write_next);
    w_addr_next     = w_base_next + ADDR_W'(w_idx_next);
    w_ad_out_next   = '0;
    if (w_stb_next.ad_oe)
      w_ad_out_next = (w_state_next == ST_ADDR) ? DATA_W'(w_addr_next) : r_wdata[w_idx_next];
  end

  // Control state and registered pad/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_vfy     <= 1'b0;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_base    <= '0;
      r_stb     <= STB_IDLE;
      r_ad_out  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_vfy     <= w_vfy_next;
      r_stb     <= w_stb_next;
      r_ad_out  <= w_ad_out_next;
      r_busy    <= (w_state_next != ST_IDLE);
      r_done    <= (w_state_next == ST_FIN);
      r_aborted <= w_abort_hit;
      if (w_accept) begin
        r_cnt  <= w_cnt_sat;
        r_wr   <= i_wr_op;
        r_base <= i_base_addr;
      end
    end
  end

  // Write data is snapshotted at start so the caller may change it mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_wdata[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < DEPTH; i++) r_wdata[i] <= i_wdata[i*DATA_W +: DATA_W];
    end
  end

  // One read-result register per burst slot; untouched slots keep old values.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rdata
    logic [DATA_W-1:0] r_rd;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_rd <= '0;
      else if (w_capture && (r_idx == IDX_W'(gi)))
        r_rd <= i_ad_in;
    end
    assign o_rdata[gi*DATA_W +: DATA_W] = r_rd;
  end

`ifdef RTC_SEQ_VERIFY_EN
  logic r_err;
  // Sticky read-back mismatch flag, cleared by the next accepted burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_accept)
      r_err <= 1'b0;
    else if ((r_state == ST_DATA) && w_tc && !i_abort && r_wr && r_vfy &&
             (i_ad_in != r_wdata[r_idx]))
      r_err <= 1'b1;
  end
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_aborted = r_aborted;
  assign o_ad_n    = r_stb.ad_n;
  assign o_cs_n    = r_stb.cs_n;
  assign o_rd_n    = r_stb.rd_n;
  assign o_wr_n    = r_stb.wr_n;
  assign o_ad_oe   = r_stb.ad_oe;
  assign o_ad_out  = r_ad_out;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with an RTC register model on the AD
// bus and a phase scoreboard (ADDR/DATA expectations queued at start).
`timescale 1ns/1ps
module tb_rtc_bus_sequencer;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int DEPTH   = 8;
  localparam int T_PHASE = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int TP4     = 4 * T_PHASE;
`ifdef RTC_SEQ_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    i_start = 1'b0, i_wr_op = 1'b0, i_abort = 1'b0;
  logic [ADDR_W-1:0]       i_base_addr = '0;
  logic [CNT_W-1:0]        i_count = '0;
  logic [DEPTH*DATA_W-1:0] i_wdata = '0;
  logic [DATA_W-1:0]       i_ad_in = '0;
  logic                    o_busy, o_done, o_aborted, o_err;
  logic [DEPTH*DATA_W-1:0] o_rdata;
  logic                    o_ad_n, o_cs_n, o_rd_n, o_wr_n, o_ad_oe;
  logic [DATA_W-1:0]       o_ad_out;

  rtc_bus_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .T_PHASE(T_PHASE)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_wr_op(i_wr_op),
    .i_base_addr(i_base_addr), .i_count(i_count), .i_wdata(i_wdata), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_rdata(o_rdata),
    .o_err(o_err), .o_ad_n(o_ad_n), .o_cs_n(o_cs_n), .o_rd_n(o_rd_n), .o_wr_n(o_wr_n),
    .o_ad_out(o_ad_out), .o_ad_oe(o_ad_oe), .i_ad_in(i_ad_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_addr;
    logic       is_wr;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mem [256];
  logic [7:0] exp_rdata [DEPTH];
  bit         corrupt = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_rdata(input string tag);
    logic [DEPTH*8-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i*8 +: 8] = exp_rdata[i];
    chk(tag, o_rdata, v);
  endtask

  // Bus monitor + RTC model: checks each phase start against the scoreboard,
  // checks values hold within a phase, stores writes, answers reads.
  exp_t       mon_e;
  logic [11:0] mon_obs, mon_exp, prev_bus;
  logic       prev_cs_n = 1'b1;
  logic [7:0] cur_addr = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!o_rd_n) chk("rd_vs_oe", {63'b0, o_ad_oe}, 64'd0);
      if (!o_cs_n && prev_cs_n) begin
        chk("phase_expected", (sb.size() > 0) ? 64'd1 : 64'd0, 64'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          if (mon_e.is_addr) begin
            mon_exp  = {4'b0101, mon_e.val};
            cur_addr = mon_e.val;
          end else if (mon_e.is_wr) begin
            mon_exp = {4'b1101, mon_e.val};
          end else begin
            mon_exp = {4'b1010, 8'h00};
          end
          mon_obs = {o_ad_n, o_rd_n, o_wr_n, o_ad_oe,
                     (mon_e.is_addr || mon_e.is_wr) ? o_ad_out : 8'h00};
          if (mon_e.is_addr) chk("addr_phase", mon_obs, mon_exp);
          else               chk("data_phase", mon_obs, mon_exp);
        end
      end else if (!o_cs_n) begin
        chk("phase_stable", {o_ad_n, o_rd_n, o_wr_n, o_ad_oe, o_ad_out}, prev_bus);
      end
      if (!o_cs_n && o_ad_n && !o_wr_n) mem[cur_addr] = o_ad_out;
      if (!o_rd_n) i_ad_in = corrupt ? mem[cur_addr] + 8'd1 : mem[cur_addr];
      else         i_ad_in = 8'h00;
    end
    prev_cs_n = o_cs_n;
    prev_bus  = {o_ad_n, o_rd_n, o_wr_n, o_ad_oe, o_ad_out};
  end

  function automatic int exp_lat(input bit wr, input int n);
    return TP4 * n * ((wr && (VFY != 0)) ? 2 : 1) + 1;
  endfunction

  // Queue expected phases, issue one burst, wait (bounded) for done.
  task automatic run_burst(input bit wr, input logic [7:0] base, input int cnt,
                           input logic [63:0] wd, input int n_push, input int abort_at,
                           input bit abort_w_start, output int lat, output logic ab,
                           output logic er, output logic [4:0] stb);
    int n_eff = (cnt > DEPTH) ? DEPTH : cnt;
    int np    = (n_push < 0) ? n_eff : n_push;
    logic [7:0] a;
    for (int i = 0; i < np; i++) begin
      a = base + 8'(i);
      sb.push_back({1'b1, 1'b0, a});
      if (wr) sb.push_back({1'b0, 1'b1, wd[i*8 +: 8]});
      else    sb.push_back({1'b0, 1'b0, 8'h00});
      if (wr && (VFY != 0)) begin
        sb.push_back({1'b1, 1'b0, a});
        sb.push_back({1'b0, 1'b0, 8'h00});
      end
    end
    @(posedge clk); #1;
    i_start = 1'b1; i_wr_op = wr; i_base_addr = base; i_count = CNT_W'(cnt);
    i_wdata = wd; i_abort = abort_w_start;
    lat = -1; ab = 1'b0; er = 1'b0; stb = 5'b0;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        i_wr_op = ~wr; i_base_addr = ~base; i_count = CNT_W'(5); i_wdata = ~wd;
        chk("busy_rise", {63'b0, o_busy}, 64'd1);
      end
      i_start = (c == 3 && n_eff > 0) ? 1'b1 : 1'b0;
      i_abort = (c == abort_at) ? 1'b1 : 1'b0;
      if (o_done) begin
        lat = c; ab = o_aborted; er = o_err;
        stb = {o_ad_n, o_cs_n, o_rd_n, o_wr_n, o_ad_oe};
        break;
      end
    end
    i_start = 1'b0; i_abort = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", {63'b0, o_done}, 64'd0);
    chk("busy_fall", {63'b0, o_busy}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    int lat;
    logic ab, er;
    logic [4:0] stb;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) exp_rdata[i] = 8'h00;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", {o_ad_n, o_cs_n, o_rd_n, o_wr_n, o_ad_oe}, 64'b11110);
    chk("reset_status", {o_busy, o_done, o_aborted, o_err, o_ad_out}, 64'd0);
    chk_rdata("reset_rdata");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write burst 0x21 x3
    run_burst(1'b1, 8'h21, 3, 64'h0000_0000_0056_3412, -1, 0, 1'b0, lat, ab, er, stb);
    chk("wr3_latency", lat, exp_lat(1'b1, 3));
    chk("wr3_flags", {ab, er}, 64'd0);

    // Read burst 0xF0 x2
    mem[8'hF0] = 8'hA5; mem[8'hF1] = 8'h5A;
    exp_rdata[0] = 8'hA5; exp_rdata[1] = 8'h5A;
    run_burst(1'b0, 8'hF0, 2, 64'h0, -1, 0, 1'b0, lat, ab, er, stb);
    chk("rd2_latency", lat, exp_lat(1'b0, 2));
    chk_rdata("rd2_rdata");

    // Address wrap: write 0xFF,0x00 then read them back
    run_burst(1'b1, 8'hFF, 2, 64'h0000_0000_0000_BBAA, -1, 0, 1'b0, lat, ab, er, stb);
    chk("wrap_wr_latency", lat, exp_lat(1'b1, 2));
    exp_rdata[0] = 8'hAA; exp_rdata[1] = 8'hBB;
    run_burst(1'b0, 8'hFF, 2, 64'h0, -1, 0, 1'b0, lat, ab, er, stb);
    chk_rdata("wrap_rd_rdata");

    // count = 0: immediate done, no bus activity
    run_burst(1'b0, 8'h10, 0, 64'h0, -1, 0, 1'b0, lat, ab, er, stb);
    chk("cnt0_latency", lat, 64'd1);
    chk("cnt0_strobes", stb, 64'b11110);

    // count = DEPTH+3 saturates to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      mem[8'h30 + 8'(i)] = 8'($urandom);
      exp_rdata[i] = mem[8'h30 + 8'(i)];
    end
    run_burst(1'b0, 8'h30, DEPTH + 3, 64'h0, -1, 0, 1'b0, lat, ab, er, stb);
    chk("sat_latency", lat, exp_lat(1'b0, DEPTH));
    chk_rdata("sat_rdata");

    // Abort during DATA of register 1 of 4 (DATA1 spans cycles 25..28)
    for (int i = 0; i < 4; i++) mem[8'h40 + 8'(i)] = 8'hC0 + 8'(i);
    exp_rdata[0] = 8'hC0;
    run_burst(1'b0, 8'h40, 4, 64'h0, 2, 26, 1'b0, lat, ab, er, stb);
    chk("abort_latency", lat, 64'd27);
    chk("abort_flag", {63'b0, ab}, 64'd1);
    chk("abort_strobes", stb, 64'b11110);
    chk_rdata("abort_rdata");

    // Abort in IDLE is ignored
    @(posedge clk); #1; i_abort = 1'b1;
    @(posedge clk); #1; i_abort = 1'b0;
    chk("idle_abort", {o_busy, o_done, o_aborted}, 64'd0);

    // Start and abort together in IDLE: start wins
    run_burst(1'b1, 8'h60, 1, 64'h77, -1, 0, 1'b1, lat, ab, er, stb);
    chk("start_abort_latency", lat, exp_lat(1'b1, 1));
    chk("start_abort_flag", {63'b0, ab}, 64'd0);

`ifdef RTC_SEQ_VERIFY_EN
    // Read-back returns written+1 -> err; correct echo -> err clear
    corrupt = 1'b1;
    run_burst(1'b1, 8'h50, 1, 64'h12, -1, 0, 1'b0, lat, ab, er, stb);
    corrupt = 1'b0;
    chk("vfy_bad_err", {63'b0, er}, 64'd1);
    run_burst(1'b1, 8'h50, 1, 64'h12, -1, 0, 1'b0, lat, ab, er, stb);
    chk("vfy_ok_err", {63'b0, er}, 64'd0);
    chk("vfy_ok_latency", lat, 64'(8 * T_PHASE + 1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
